dac_output_stage: RTL
=====================

// Module: dac_output_stage
// PURPOSE
//  Final TX stage after upsampler_4: takes signed 1s17 samples at the sample rate and drives one 14-bit DAC channel.
//  Applies gain shift, rounding and saturation, then converts to offset binary and issues the DAC write strobe.
//  Also provides built-in test patterns (ramp, square, mute) and a saturating overflow counter for bench/scope checks.
// PARAMETERS
//  IN_W       18  input sample width, signed 1s17
//  DAC_W      14  DAC code width, offset binary
//  RAMP_STEP  1   ramp increment per sample, in DAC codes
//  SQ_HALF    8   square-wave half period, in samples (>=1)
//  OVF_W      16  overflow counter width
// PORTS
//  clk         in   1      system clock (sys_clk)
//  reset       in   1      synchronous, active-high reset
//  sam_clk_en  in   1      one-clk sample strobe
//  mode        in   2      0 pass, 1 ramp, 2 square, 3 mute
//  shift       in   3      left shift 0..7 applied to data_in (pass mode only)
//  clr_ovf     in   1      clears ovf_count and ovf_flag
//  data_in     in   IN_W   signed sample from upsampler
//  dac_data    out  DAC_W  offset-binary DAC code
//  dac_wrt     out  1      one-clk write pulse, the cycle after dac_data updates
//  ovf_flag    out  1      sticky: saturation has occurred
//  ovf_count   out  OVF_W  saturation events, saturates at all-ones
//  mode_active out  2      mode currently in effect
// BEHAVIOUR
//  Reset (one clk, synchronous): dac_data=14'h2000 (midscale), dac_wrt=0, ovf_flag=0, ovf_count=0,
//   mode_active=3, state=IDLE, pipeline regs=0, ramp acc=0, square counter=0. Reset mid-stream aborts
//   the current sample; no dac_wrt is issued for it.
//  FSM states: IDLE, PASS, RAMP, SQUARE, MUTE. The FSM moves only on clocks with sam_clk_en=1.
//   IDLE -> state selected by mode on the first strobe. Any state -> new state on a strobe where mode != mode_active.
//   Entering RAMP clears ramp acc to 0. Entering SQUARE clears the square counter and sets the phase to high.
//   mode_active follows the state; it updates on the same edge as the transition.
//  Pass datapath, 2-stage pipeline, each stage advances only on sam_clk_en:
//   s1 = (sign-extended data_in <<< shift) + 8, computed at IN_W+8 bits (round-half-up at bit 3).
//   Saturate s1 to [-131072, 131071]. Stage1 reg <= sat(s1)[17:4], i.e. floor after rounding.
//   Stage2: dac_data <= {~stage1[13], stage1[12:0]}.
//   Latency: a sample captured on strobe k appears on dac_data at strobe k+1.
//  Patterns: each computed directly into stage1 on the strobe; they share the stage2/dac_wrt timing.
//   Ramp: code = acc, then acc += RAMP_STEP with modulo-2^14 wrap (16383+1 -> 0).
//   Square: code 14'h3000 for SQ_HALF samples, then 14'h1000 for SQ_HALF samples, repeating.
//   Mute: code 14'h2000.
//  dac_wrt: high exactly one clk, the clk after each dac_data update. It is never asserted in IDLE or during reset.
//  Overflow: an event occurs when sat() clips in pass mode; rounding overflow counts as an event.
//   On an event: ovf_flag <= 1 and ovf_count increments, holding at 2^OVF_W-1.
//   clr_ovf alone: both outputs clear. clr_ovf together with an event: ovf_count=1, ovf_flag=1.
//  The mode change and the data path run on the same strobe; the first sample in the new mode uses the new
//   mode's stage1 value. The old stage1 value is still emitted on that strobe, so there is no gap.
// TESTING
//  Reset, then mode=0, shift=0, data_in=0 held for 3 strobes -> dac_data=14'h2000; dac_wrt pulses once per strobe.
//  data_in=87381, shift=0 -> dac_data=14'h3555 one strobe later; ovf_count stays 0.
//  data_in=87381, shift=1 -> dac_data=14'h3FFF, ovf_flag=1, ovf_count=1.
//   data_in=-131072, shift=0 -> dac_data=14'h0000, no overflow.
//   data_in=131071 -> dac_data=14'h3FFF, ovf_count increments (rounding clip).
//  mode=1, RAMP_STEP=1, run 16386 strobes -> codes 0,1,...,16383,0,1; dac_wrt count = strobe count.
//   mode=2 -> 8x 14'h3000, then 8x 14'h1000, repeating.
//  clr_ovf asserted on the same clk as a clipping sample -> ovf_count=1, ovf_flag=1.
//   reset asserted mid-ramp -> next clk dac_data=14'h2000, dac_wrt=0, mode_active=3.

Source files
------------

// File: rtl/dac_output_stage.sv
// Final TX stage: gain shift, round, saturate and offset-binary convert a 1s17 sample for a 14-bit DAC,
// with ramp/square/mute test patterns, a delayed write strobe and a saturating overflow counter.
module dac_output_stage #(
  parameter int IN_W      = 18,
  parameter int DAC_W     = 14,
  parameter int RAMP_STEP = 1,
  parameter int SQ_HALF   = 8,
  parameter int OVF_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic [1:0]              mode,
  input  logic [2:0]              shift,
  input  logic                    clr_ovf,
  input  logic signed [IN_W-1:0]  data_in,
  output logic [DAC_W-1:0]        dac_data,
  output logic                    dac_wrt,
  output logic                    ovf_flag,
  output logic [OVF_W-1:0]        ovf_count,
  output logic [1:0]              mode_active
);

  localparam int WW   = IN_W + 8;
  localparam int FRAC = IN_W - DAC_W;
  localparam int SQW  = $clog2(SQ_HALF) + 1;

  localparam logic signed [WW-1:0] ROUND  = WW'(2 ** (FRAC - 1));
  localparam logic signed [WW-1:0] Q_MAX  = WW'((2 ** (DAC_W - 1)) - 1);
  localparam logic signed [WW-1:0] Q_MIN  = WW'(-(2 ** (DAC_W - 1)));
  localparam logic [DAC_W-1:0]     MID_CODE   = DAC_W'(1 << (DAC_W - 1));
  localparam logic [DAC_W-1:0]     SQ_HI_CODE = DAC_W'(3 << (DAC_W - 2));
  localparam logic [DAC_W-1:0]     SQ_LO_CODE = DAC_W'(1 << (DAC_W - 2));

  typedef enum logic [2:0] {ST_IDLE, ST_PASS, ST_RAMP, ST_SQUARE, ST_MUTE} state_t;

  function automatic state_t mode_to_state(input logic [1:0] m);
    case (m)
      2'd0:    return ST_PASS;
      2'd1:    return ST_RAMP;
      2'd2:    return ST_SQUARE;
      default: return ST_MUTE;
    endcase
  endfunction

  state_t             state_q, state_d, tgt;
  logic [1:0]         mode_active_q, mode_active_d;
  logic [DAC_W-1:0]   stage1_q, stage1_d;
  logic [DAC_W-1:0]   ramp_acc_q, ramp_acc_d, ramp_cur;
  logic [SQW-1:0]     sq_cnt_q, sq_cnt_d, sq_cur;
  logic               sq_phase_q, sq_phase_d, sq_ph_cur;
  logic [DAC_W-1:0]   dac_data_q, dac_data_d;
  logic               wrt_pend_q, wrt_pend_d;
  logic               dac_wrt_q, dac_wrt_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic [OVF_W-1:0]   ovf_count_q, ovf_count_d;
  logic               entering, ovf_event;

  // Pass datapath: the shift >>> FRAC is a floor, so clipping can be judged on the quotient directly.
  logic signed [WW-1:0] ext_s, sum_s, quo_s;
  logic                 clip_hi, clip_lo;
  logic [DAC_W-1:0]     pass_code;

  always_comb begin
    ext_s     = WW'(data_in);
    sum_s     = (ext_s <<< shift) + ROUND;
    quo_s     = sum_s >>> FRAC;
    clip_hi   = quo_s > Q_MAX;
    clip_lo   = quo_s < Q_MIN;
    pass_code = clip_hi ? {1'b0, {(DAC_W-1){1'b1}}} :
                clip_lo ? {1'b1, {(DAC_W-1){1'b0}}} : quo_s[DAC_W-1:0];
  end

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    mode_active_d = mode_active_q;
    stage1_d      = stage1_q;
    ramp_acc_d    = ramp_acc_q;
    sq_cnt_d      = sq_cnt_q;
    sq_phase_d    = sq_phase_q;
    dac_data_d    = dac_data_q;
    wrt_pend_d    = 1'b0;
    dac_wrt_d     = wrt_pend_q;
    ovf_flag_d    = ovf_flag_q;
    ovf_count_d   = ovf_count_q;
    tgt           = state_q;
    entering      = 1'b0;
    ovf_event     = 1'b0;
    ramp_cur      = '0;
    sq_cur        = '0;
    sq_ph_cur     = 1'b1;

    if (sam_clk_en) begin
      if (state_q == ST_IDLE || mode != mode_active_q) begin
        tgt           = mode_to_state(mode);
        mode_active_d = mode;
      end
      entering = (tgt != state_q);
      state_d  = tgt;

      // Stage 2 emits the previous stage-1 value, so a mode change leaves no gap in the output.
      if (state_q != ST_IDLE) begin
        dac_data_d = {~stage1_q[DAC_W-1], stage1_q[DAC_W-2:0]};
        wrt_pend_d = 1'b1;
      end

      case (tgt)
        ST_PASS: begin
          stage1_d  = pass_code;
          ovf_event = clip_hi | clip_lo;
        end
        ST_RAMP: begin
          ramp_cur   = entering ? '0 : ramp_acc_q;
          stage1_d   = ramp_cur ^ MID_CODE;
          ramp_acc_d = ramp_cur + DAC_W'(RAMP_STEP);
        end
        ST_SQUARE: begin
          sq_cur    = entering ? '0 : sq_cnt_q;
          sq_ph_cur = entering ? 1'b1 : sq_phase_q;
          stage1_d  = (sq_ph_cur ? SQ_HI_CODE : SQ_LO_CODE) ^ MID_CODE;
          if (sq_cur == SQW'(SQ_HALF - 1)) begin
            sq_cnt_d   = '0;
            sq_phase_d = ~sq_ph_cur;
          end else begin
            sq_cnt_d   = sq_cur + SQW'(1);
            sq_phase_d = sq_ph_cur;
          end
        end
        default: stage1_d = '0;
      endcase
    end

    if (clr_ovf) begin
      ovf_flag_d  = ovf_event;
      ovf_count_d = ovf_event ? OVF_W'(1) : '0;
    end else if (ovf_event) begin
      ovf_flag_d = 1'b1;
      if (ovf_count_q != '1) ovf_count_d = ovf_count_q + OVF_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_active_q <= 2'd3;
      stage1_q      <= '0;
      ramp_acc_q    <= '0;
      sq_cnt_q      <= '0;
      sq_phase_q    <= 1'b1;
      dac_data_q    <= MID_CODE;
      wrt_pend_q    <= 1'b0;
      dac_wrt_q     <= 1'b0;
      ovf_flag_q    <= 1'b0;
      ovf_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      mode_active_q <= mode_active_d;
      stage1_q      <= stage1_d;
      ramp_acc_q    <= ramp_acc_d;
      sq_cnt_q      <= sq_cnt_d;
      sq_phase_q    <= sq_phase_d;
      dac_data_q    <= dac_data_d;
      wrt_pend_q    <= wrt_pend_d;
      dac_wrt_q     <= dac_wrt_d;
      ovf_flag_q    <= ovf_flag_d;
      ovf_count_q   <= ovf_count_d;
    end
  end

  assign dac_data    = dac_data_q;
  assign dac_wrt     = dac_wrt_q;
  assign ovf_flag    = ovf_flag_q;
  assign ovf_count   = ovf_count_q;
  assign mode_active = mode_active_q;

endmodule
